btb_ctrl: RTL and testbench
===========================

Name: btb_ctrl

Overview:
Sequencer and write-port arbiter for the 128-entry branch target buffer array ({target[31:0], taken} per entry). It clears the array after reset and on a flush request, and arbitrates the single BTB write port between the clear sweep and EX-stage branch updates. It holds one deferred update while a sweep is running and gates fetch-side prediction until the array is valid. It sits between the EX stage and the BTB storage and replaces any behavioural reset loop in the storage.

Parameters:
IDX_W, 7, index width of BTB array
ENTRIES, 128, number of BTB entries (must equal 2**IDX_W)
TGT_W, 32, branch target width
CNT_W, 16, width of dropped-update counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush_req  in  1  single-cycle request to invalidate all entries
upd_valid  in  1  EX stage resolved a branch this cycle
upd_idx  in  IDX_W  BTB index of resolved branch (PCE low bits)
upd_target  in  TGT_W  resolved branch target
upd_taken  in  1  resolved direction
wr_en  out  1  BTB write enable
wr_idx  out  IDX_W  BTB write index
wr_data  out  TGT_W+1  {target, taken}
pred_enable  out  1  BTB contents valid; fetch uses isTaken only when 1
busy  out  1  sweep in progress (= !pred_enable)
flush_done  out  1  one-cycle pulse when a sweep completes
drop_cnt  out  CNT_W  updates lost during sweeps, saturating

Behaviour:
- States: SWEEP, IDLE. Reset forces SWEEP with sweep counter 0.
- Reset values: wr_en=0, wr_idx=0, wr_data=0, pred_enable=0, busy=1, flush_done=0, drop_cnt=0, pending slot empty.
- All outputs are registered. A request sampled at edge t appears on wr_* after edge t, i.e. one cycle of latency.
- SWEEP:
  - Each cycle: wr_en=1, wr_idx=cnt, wr_data=0, cnt++.
  - After writing index ENTRIES-1: go to IDLE, pulse flush_done for one cycle, set pred_enable=1.
  - A sweep takes exactly ENTRIES write cycles.
- IDLE:
  - flush_req=1: go to SWEEP with cnt=0 and pred_enable=0. A same-cycle upd_valid is discarded without counting. A pending update is discarded.
  - Else if pending valid: write pending. If upd_valid, capture the new update into pending.
  - Else if upd_valid: write {upd_target, upd_taken} to upd_idx.
  - Else: wr_en=0.
- Updates during SWEEP:
  - First upd_valid goes to the pending slot (depth 1).
  - Further upd_valid while pending is full: dropped, drop_cnt++ (saturates at 2**CNT_W-1, no wrap).
  - The pending update is written in the first IDLE cycle after the sweep.
- flush_req during SWEEP: restart the sweep at cnt=0. The pending slot is cleared. No flush_done pulse for the aborted sweep.
- Writes to the same index on consecutive cycles are issued in order (last write wins).
- rst asserted mid-sweep or mid-update: immediate return to reset values. drop_cnt is cleared.
- drop_cnt is cleared only by rst.

Test Plan:
- Release rst at cycle 0 -> wr_en=1 for 128 consecutive cycles with wr_idx 0..127 and wr_data=0. flush_done pulses once; pred_enable rises the following cycle.
- IDLE, upd_valid with idx=5, target=0x0000_0040, taken=1 -> next cycle wr_en=1, wr_idx=5, wr_data=0x81.
- flush_req in IDLE plus simultaneous upd_valid idx=9 -> no write to 9 with that data. Full 128-cycle sweep runs; drop_cnt unchanged.
- Three updates (idx 1, 2, 3) during a sweep -> idx 1 written first cycle after flush_done. idx 2 and 3 are not written; drop_cnt=2.
- flush_req at sweep cnt=60 -> wr_idx returns to 0 next cycle. Total sweep writes = 61+128; one flush_done.
- Force drop_cnt to 0xFFFF via repeated drops, then one more drop -> drop_cnt stays 0xFFFF. rst asserted at sweep cnt=30 -> all outputs at reset values immediately; new sweep starts from 0.

Source files
------------

// File: rtl/btb_ctrl.sv
// Clear sequencer and single write-port arbiter for the branch target buffer.
// Sweeps every entry to zero after reset or flush, defers one EX update during a sweep.
`timescale 1ns/1ps
module btb_ctrl #(
  parameter int IDX_W   = 7,
  parameter int ENTRIES = 128,
  parameter int TGT_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_req,
  input  logic               upd_valid,
  input  logic [IDX_W-1:0]   upd_idx,
  input  logic [TGT_W-1:0]   upd_target,
  input  logic               upd_taken,
  output logic               wr_en,
  output logic [IDX_W-1:0]   wr_idx,
  output logic [TGT_W:0]     wr_data,
  output logic               pred_enable,
  output logic               busy,
  output logic               flush_done,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               dbg_state_o
);

  typedef enum logic {S_SWEEP = 1'b0, S_IDLE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               pend_vld_q, pend_vld_d;
  logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
  logic [TGT_W:0]     pend_data_q, pend_data_d;
  logic               wr_en_q, wr_en_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [TGT_W:0]     wr_data_q, wr_data_d;
  logic               pred_q, pred_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic [TGT_W:0]     upd_word;
  logic               sweep_last;

  assign upd_word   = {upd_target, upd_taken};
  assign sweep_last = (cnt_q == IDX_W'(ENTRIES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_SWEEP;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_idx_q  <= '0;
      pend_data_q <= '0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      pred_q      <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_idx_q  <= pend_idx_d;
      pend_data_q <= pend_data_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      pred_q      <= pred_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_idx_d  = pend_idx_q;
    pend_data_d = pend_data_q;
    wr_en_d     = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    pred_d      = pred_q;
    done_d      = 1'b0;
    drop_d      = drop_q;

    case (state_q)
      S_SWEEP: begin
        wr_en_d   = 1'b1;
        wr_idx_d  = cnt_q;
        wr_data_d = '0;
        pred_d    = 1'b0;
        if (flush_req) begin
          // Restart: the aborted sweep never reports completion.
          cnt_d      = '0;
          pend_vld_d = 1'b0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
          if (sweep_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          if (upd_valid) begin
            if (!pend_vld_q) begin
              pend_vld_d  = 1'b1;
              pend_idx_d  = upd_idx;
              pend_data_d = upd_word;
            end else if (drop_q != '1) begin
              drop_d = drop_q + CNT_W'(1);
            end
          end
        end
      end
      S_IDLE: begin
        pred_d = 1'b1;
        if (flush_req) begin
          state_d    = S_SWEEP;
          cnt_d      = '0;
          pred_d     = 1'b0;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          // Deferred update drains first so writes stay in arrival order.
          wr_en_d    = 1'b1;
          wr_idx_d   = pend_idx_q;
          wr_data_d  = pend_data_q;
          pend_vld_d = upd_valid;
          if (upd_valid) begin
            pend_idx_d  = upd_idx;
            pend_data_d = upd_word;
          end
        end else if (upd_valid) begin
          wr_en_d   = 1'b1;
          wr_idx_d  = upd_idx;
          wr_data_d = upd_word;
        end
      end
      default: state_d = S_SWEEP;
    endcase
  end

  assign wr_en       = wr_en_q;
  assign wr_idx      = wr_idx_q;
  assign wr_data     = wr_data_q;
  assign pred_enable = pred_q;
  assign busy        = !pred_q;
  assign flush_done  = done_q;
  assign drop_cnt    = drop_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_btb_ctrl.sv
// Scoreboard bench for btb_ctrl: expected BTB writes queued as stimulus is driven,
// popped and compared whenever the DUT raises wr_en.
`timescale 1ns/1ps
module tb_btb_ctrl;
  localparam int IDX_W   = 7;
  localparam int ENTRIES = 128;
  localparam int TGT_W   = 32;
  localparam int CNT_W   = 16;
  localparam int W       = IDX_W + TGT_W + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush_req = 1'b0;
  logic             upd_valid = 1'b0;
  logic [IDX_W-1:0] upd_idx = '0;
  logic [TGT_W-1:0] upd_target = '0;
  logic             upd_taken = 1'b0;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [TGT_W:0]   wr_data;
  logic             pred_enable;
  logic             busy;
  logic             flush_done;
  logic [CNT_W-1:0] drop_cnt;
  logic             dbg_state;

  logic [W-1:0] exp_q[$];
  int chk_cnt  = 0;
  int err_cnt  = 0;
  int done_cnt = 0;
  int exp_drop = 0;
  bit mon_en   = 1'b1;
  bit prev_done = 1'b0;

  always #5 clk = ~clk;

  btb_ctrl #(.IDX_W(IDX_W), .ENTRIES(ENTRIES), .TGT_W(TGT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .upd_valid(upd_valid),
    .upd_idx(upd_idx), .upd_target(upd_target), .upd_taken(upd_taken),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .pred_enable(pred_enable),
    .busy(busy), .flush_done(flush_done), .drop_cnt(drop_cnt), .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int n);
    logic [TGT_W:0] zero = '0;
    for (int i = 0; i < n; i++) exp_q.push_back({IDX_W'(i), zero});
  endtask

  task automatic drive_upd(input logic [IDX_W-1:0] idx, input logic [TGT_W-1:0] tgt,
                           input logic tk, input bit expect_write);
    upd_valid  = 1'b1;
    upd_idx    = idx;
    upd_target = tgt;
    upd_taken  = tk;
    if (expect_write) exp_q.push_back({idx, tgt, tk});
  endtask

  task automatic wait_pe(input int budget);
    int n = 0;
    while (!pred_enable && n < budget) begin
      tick();
      n++;
    end
    check("pe_timeout", (n < budget), 1);
  endtask

  task automatic check_reset_vals();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_idx", wr_idx, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_pred", pred_enable, 0);
    check("rst_busy", busy, 1);
    check("rst_done", flush_done, 0);
    check("rst_drop", drop_cnt, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (wr_en) begin
        if (exp_q.size() == 0) check("wr_extra", {1'b1, wr_idx, wr_data}, {1'b0, {W{1'b0}}});
        else check("wr", {wr_idx, wr_data}, exp_q.pop_front());
      end
      if (prev_done) check("pe_after_done", pred_enable, 1);
      if (flush_done) done_cnt++;
      prev_done = flush_done;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and the power-on sweep.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    tick();
    rst = 1'b0;
    push_sweep(ENTRIES);
    wait_pe(300);
    check("sweep0_done", done_cnt, 1);
    check("sweep0_busy", busy, 0);
    check("sweep0_drop", drop_cnt, 0);

    // Directed IDLE update.
    drive_upd(7'd5, 32'h0000_0040, 1'b1, 1'b1);
    tick();
    upd_valid = 1'b0;
    check("upd5_en", wr_en, 1);
    check("upd5_word", {wr_idx, wr_data}, {7'd5, 33'h81});

    // Back-to-back updates on a few indices, repeats must stay in order.
    for (int i = 0; i < 8; i++) begin
      drive_upd(IDX_W'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), 1'b1);
      tick();
    end
    upd_valid = 1'b0;
    repeat (3) tick();

    // Flush in IDLE with a same-cycle update that must vanish.
    flush_req = 1'b1;
    drive_upd(7'd9, 32'hDEAD_BEEF, 1'b1, 1'b0);
    push_sweep(ENTRIES);
    tick();
    flush_req = 1'b0;
    upd_valid = 1'b0;
    check("flush_pred", pred_enable, 0);
    check("flush_busy", busy, 1);
    check("flush_wr_en", wr_en, 0);
    wait_pe(300);
    check("flush_done_cnt", done_cnt, 2);
    check("flush_drop", drop_cnt, exp_drop);

    // Three updates during a sweep: first deferred, two dropped.
    flush_req = 1'b1;
    push_sweep(ENTRIES);
    tick();
    flush_req = 1'b0;
    repeat (5) tick();
    drive_upd(7'd1, 32'h1111_0000, 1'b1, 1'b1);
    tick();
    drive_upd(7'd2, 32'h2222_0000, 1'b0, 1'b0);
    tick();
    drive_upd(7'd3, 32'h3333_0000, 1'b1, 1'b0);
    tick();
    upd_valid = 1'b0;
    exp_drop += 2;
    wait_pe(300);
    repeat (3) tick();
    check("pend_drop", drop_cnt, exp_drop);
    check("pend_done_cnt", done_cnt, 3);

    // Flush arriving at sweep count 60 restarts from index 0.
    flush_req = 1'b1;
    push_sweep(61);
    tick();
    flush_req = 1'b0;
    repeat (60) tick();
    flush_req = 1'b1;
    push_sweep(ENTRIES);
    tick();
    flush_req = 1'b0;
    check("abort_idx60", wr_idx, 60);
    tick();
    check("abort_idx0", wr_idx, 0);
    wait_pe(300);
    check("abort_done_cnt", done_cnt, 4);
    check("abort_q_empty", exp_q.size(), 0);

    // Saturate the drop counter with continuous updates across repeated flushes.
    mon_en = 1'b0;
    prev_done = 1'b0;
    for (int w = 0; w < 700; w++) begin
      flush_req = 1'b1;
      drive_upd(IDX_W'($urandom_range(0, 127)), $urandom, 1'b1, 1'b0);
      tick();
      flush_req = 1'b0;
      for (int c = 0; c < 99; c++) begin
        drive_upd(IDX_W'($urandom_range(0, 127)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        tick();
      end
      exp_drop = (exp_drop + 98 > 65535) ? 65535 : exp_drop + 98;
      if (w == 599) check("drop_mid", drop_cnt, exp_drop);
    end
    check("drop_sat", drop_cnt, 16'hFFFF);
    tick();
    check("drop_sat_hold", drop_cnt, 16'hFFFF);
    upd_valid = 1'b0;

    // Asynchronous reset in the middle of a sweep.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (30) tick();
    check("pre_rst_idx", wr_idx, 29);
    rst = 1'b1;
    #1;
    check_reset_vals();
    exp_q.delete();
    exp_drop = 0;
    done_cnt = 0;
    prev_done = 1'b0;
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    push_sweep(ENTRIES);
    wait_pe(300);
    check("rst_sweep_done", done_cnt, 1);
    check("rst_sweep_drop", drop_cnt, 0);
    repeat (2) tick();
    check("final_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
